bpm_pos_calc: RTL and testbench
===============================

BPM_POS_CALC -- requirements
Module: bpm_pos_calc

Interface
REQ-001 SHALL have parameter DATA_W, default 32, unsigned width of each electrode input.
REQ-002 SHALL have parameter DIA_W, default 16, unsigned width of Diameter.
REQ-003 SHALL have parameter SCALE, default 250, integer position scale (1000/4), fitting SCALE_W bits.
REQ-004 SHALL have parameter SCALE_W, default 8, width of SCALE; define N = DATA_W+DIA_W+SCALE_W and P = DIA_W+SCALE_W+1.
REQ-005 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port data_valid, input, 1, request to start a calculation.
REQ-008 SHALL have ports A_IN, B_IN, C_IN, D_IN, input, DATA_W each, unsigned electrode amplitudes.
REQ-009 SHALL have port Diameter, input, DIA_W, unsigned pickup diameter.
REQ-010 SHALL have ports X, Y, output, P each, signed two's-complement positions.
REQ-011 SHALL have port S, output, DATA_W+2, unsigned sum A+B+C+D.
REQ-012 SHALL have port err, output, 2, {Y divide-by-zero, X divide-by-zero}.
REQ-013 SHALL have port busy, output, 1, high while a calculation is in progress.
REQ-014 SHALL have port rdy, output, 1, single-cycle result strobe.

Function
REQ-015 SHALL accept a request only when idle and data_valid is high, capturing all inputs on that edge (edge E0); busy goes high at E0.
REQ-016 SHALL ignore data_valid while busy, with no effect on the calculation in progress.
REQ-017 SHALL compute X = trunc_toward_zero(Diameter*SCALE*(A-B)/(A+B)) and Y likewise with C, D, using exact integer arithmetic and no precision loss before the division.
REQ-018 SHALL compute each quotient by sign-magnitude restoring division, one quotient bit per cycle over N cycles, with one shared divider used for X and then Y.
REQ-019 SHALL use the state sequence IDLE -> PREP_X -> DIV_X (N cycles) -> PREP_Y -> DIV_Y (N cycles) -> DONE -> IDLE.
REQ-020 SHALL assert rdy for exactly one cycle, and update X, Y, S and err, at edge E0+2N+4 (116 cycles at defaults); busy falls on that same edge.
REQ-021 SHALL, when a denominator is 0, force that position to 0 and set its err bit, keeping latency unchanged.
REQ-022 SHALL hold X, Y, S and err stable between rdy strobes.
REQ-023 SHALL accept a data_valid that is high in the cycle rdy is high (back-to-back operation, next rdy 2N+5 cycles later).
REQ-024 SHALL keep |X|, |Y| <= Diameter*SCALE, with no overflow for any input values.

Reset
REQ-025 SHALL, while rst is high, immediately force the state to IDLE, X=Y=0, S=0, err=0, busy=0 and rdy=0.
REQ-026 SHALL abandon any calculation in progress on a reset asserted mid-operation, with no rdy produced for it.
REQ-027 SHALL accept a new request on the first edge after rst deasserts.

Configuration
REQ-028 SHALL, with macro BPM_POS_DROP_CNT_EN defined, provide output drop_cnt (16 bits, reset 0) that increments on every cycle with data_valid high while busy, saturating at 0xFFFF.
REQ-029 SHALL, without BPM_POS_DROP_CNT_EN, omit the drop_cnt port and its logic entirely, with all other behaviour identical.

Verification (defaults)
REQ-030 SHALL verify: Diameter=60, A=300, B=100, C=200, D=200 -> X=7500, Y=0, S=800, err=0, rdy exactly 116 cycles after accept.
REQ-031 SHALL verify: Diameter=60, A=100, B=300, C=0, D=400 -> X=-7500, Y=-15000.
REQ-032 SHALL verify: Diameter=1, A=1, B=2, C=5, D=0 -> X=-83 (truncated toward zero), Y=250.
REQ-033 SHALL verify: A=B=0, C=10, D=0, Diameter=60 -> X=0, err=2'b01, Y=15000.
REQ-034 SHALL verify: data_valid pulsed 10 cycles after accept -> ignored, results unchanged, and with the macro defined drop_cnt=1; data_valid held high through rdy -> back-to-back acceptance.
REQ-035 SHALL verify: rst asserted 50 cycles into a calculation -> outputs 0 at once, no rdy; a new request then completes correctly.

Source files
------------

// File: rtl/bpm_pos_calc.sv
// BPM position calculator: X/Y from four electrode sums via one shared serial divider.
// Optional drop counter for requests seen while busy: define BPM_POS_DROP_CNT_EN.
module bpm_pos_calc #(
    parameter int DATA_W  = 32,
    parameter int DIA_W   = 16,
    parameter int SCALE   = 250,
    parameter int SCALE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_valid,
    input  logic [DATA_W-1:0]       A_IN,
    input  logic [DATA_W-1:0]       B_IN,
    input  logic [DATA_W-1:0]       C_IN,
    input  logic [DATA_W-1:0]       D_IN,
    input  logic [DIA_W-1:0]        Diameter,
    output logic [DIA_W+SCALE_W:0]  X,
    output logic [DIA_W+SCALE_W:0]  Y,
    output logic [DATA_W+1:0]       S,
    output logic [1:0]              err,
    output logic                    busy,
    output logic                    rdy
`ifdef BPM_POS_DROP_CNT_EN
    ,
    output logic [15:0]             drop_cnt
`endif
);

    localparam int N  = DATA_W + DIA_W + SCALE_W;
    localparam int P  = DIA_W + SCALE_W + 1;
    localparam int R  = DATA_W + 2;
    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] SCALE_N = N'(SCALE);

    typedef enum logic [2:0] {
        IDLE, PREP_X, DIV_X, PREP_Y, DIV_Y, DONE
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] a_r, b_r, c_r, d_r;
    logic [DIA_W-1:0]  dia_r;
    logic [CW-1:0]     cnt;
    logic [R-1:0]      rem;
    logic [N-1:0]      quo;
    logic [DATA_W:0]   den;
    logic              neg;
    logic              x_err, y_err;
    logic [P-1:0]      x_res, y_res;

    logic              sel_y;
    logic [DATA_W-1:0] op_p, op_n, diff;
    logic              op_neg;
    logic [DATA_W:0]   op_sum;
    logic [N-1:0]      num;
    logic [R:0]        rem_sh;
    logic [R-1:0]      rem_sub;
    logic              ge;
    logic [P-1:0]      mag, res;
    logic              last;
    logic [DATA_W+1:0] sum4;

    assign busy = (state != IDLE);

    // Operands for the pair being prepared; magnitudes and sign kept apart
    always_comb begin
        sel_y   = (state == PREP_Y);
        op_p    = sel_y ? c_r : a_r;
        op_n    = sel_y ? d_r : b_r;
        op_neg  = (op_n > op_p);
        diff    = op_neg ? (op_n - op_p) : (op_p - op_n);
        op_sum  = {1'b0, op_p} + {1'b0, op_n};
        num     = N'(dia_r) * SCALE_N * N'(diff);
        rem_sh  = {rem, quo[N-1]};
        rem_sub = R'(rem_sh - (R+1)'(den));
        ge      = (rem_sh >= (R+1)'(den));
        mag     = quo[P-1:0];
        res     = (den == '0) ? '0 : (neg ? ('0 - mag) : mag);
        last    = (cnt == CW'(N - 1));
        sum4    = {2'b0, a_r} + {2'b0, b_r} + {2'b0, c_r} + {2'b0, d_r};
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (data_valid) state_nx = PREP_X;
            PREP_X:  state_nx = DIV_X;
            DIV_X:   if (last) state_nx = PREP_Y;
            PREP_Y:  state_nx = DIV_Y;
            DIV_Y:   if (last) state_nx = DONE;
            DONE:    if (cnt == CW'(1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= '0;
            d_r   <= '0;
            dia_r <= '0;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            den   <= '0;
            neg   <= 1'b0;
            x_err <= 1'b0;
            y_err <= 1'b0;
            x_res <= '0;
            y_res <= '0;
            X     <= '0;
            Y     <= '0;
            S     <= '0;
            err   <= '0;
            rdy   <= 1'b0;
        end else begin
            rdy <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (data_valid) begin
                        a_r   <= A_IN;
                        b_r   <= B_IN;
                        c_r   <= C_IN;
                        d_r   <= D_IN;
                        dia_r <= Diameter;
                    end
                end
                // PREP_Y also retires the finished X quotient
                PREP_X, PREP_Y: begin
                    cnt <= '0;
                    rem <= '0;
                    quo <= num;
                    den <= op_sum;
                    neg <= op_neg;
                    if (sel_y) begin
                        x_res <= res;
                        x_err <= (den == '0);
                    end
                end
                DIV_X, DIV_Y: begin
                    cnt <= last ? '0 : cnt + CW'(1);
                    rem <= ge ? rem_sub : rem_sh[R-1:0];
                    quo <= {quo[N-2:0], ge};
                end
                DONE: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == '0) begin
                        y_res <= res;
                        y_err <= (den == '0);
                    end else begin
                        X   <= x_res;
                        Y   <= y_res;
                        S   <= sum4;
                        err <= {y_err, x_err};
                        rdy <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

`ifdef BPM_POS_DROP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt <= '0;
        else if (data_valid && busy && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_bpm_pos_calc.sv
// Testbench for bpm_pos_calc: fixed vectors, random vectors vs. arithmetic model,
// plus ignore / back-to-back / mid-operation reset sequences.
module tb_bpm_pos_calc;

    localparam int DATA_W = 32;
    localparam int DIA_W  = 16;
    localparam int SCALE  = 250;
    localparam int P      = 25;
    localparam int LAT    = 116;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              data_valid = 1'b0;
    logic [31:0]       a_in = '0, b_in = '0, c_in = '0, d_in = '0;
    logic [15:0]       dia = '0;
    logic [P-1:0]      x, y;
    logic [33:0]       s;
    logic [1:0]        err;
    logic              busy, rdy;
`ifdef BPM_POS_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    bpm_pos_calc dut (
        .clk(clk),
        .rst(rst),
        .data_valid(data_valid),
        .A_IN(a_in),
        .B_IN(b_in),
        .C_IN(c_in),
        .D_IN(d_in),
        .Diameter(dia),
        .X(x),
        .Y(y),
        .S(s),
        .err(err),
        .busy(busy),
        .rdy(rdy)
`ifdef BPM_POS_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic [31:0] a, b, c, d;
        logic [15:0] dia;
        longint      ex, ey, es, ee;
    } vec_t;

    int nvec = 0;
    int nfail = 0;
    int t0 = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint pos(input logic [31:0] p, input logic [31:0] n,
                                   input logic [15:0] d);
        longint lp, ln;
        lp = longint'(p);
        ln = longint'(n);
        if (lp + ln == 0) return 0;
        return (longint'(d) * SCALE * (lp - ln)) / (lp + ln);
    endfunction

    function automatic vec_t model(input logic [31:0] a, b, c, d, input logic [15:0] dd);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.d = d; v.dia = dd;
        v.ex = pos(a, b, dd);
        v.ey = pos(c, d, dd);
        v.es = longint'(a) + longint'(b) + longint'(c) + longint'(d);
        v.ee = ((longint'(c) + longint'(d) == 0) ? 2 : 0)
             + ((longint'(a) + longint'(b) == 0) ? 1 : 0);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        a_in = v.a; b_in = v.b; c_in = v.c; d_in = v.d; dia = v.dia;
    endtask

    task automatic start(input vec_t v);
        @(negedge clk);
        drive(v);
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (rdy !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic chk_res(input string tag, input vec_t v);
        chk({tag, " X"}, longint'($signed(x)), v.ex);
        chk({tag, " Y"}, longint'($signed(y)), v.ey);
        chk({tag, " S"}, longint'(s), v.es);
        chk({tag, " err"}, longint'(err), v.ee);
    endtask

    task automatic run(input string tag, input vec_t v);
        start(v);
        wait_rdy();
        chk({tag, " latency"}, cyc - t0, LAT);
        chk_res(tag, v);
        @(posedge clk); #1;
        chk({tag, " rdy pulse"}, rdy, 0);
    endtask

    vec_t vt[4];
    vec_t v, w;

    initial begin
        vt[0] = '{a: 300, b: 100, c: 200, d: 200, dia: 60,
                  ex: 7500, ey: 0, es: 800, ee: 0};
        vt[1] = '{a: 100, b: 300, c: 0, d: 400, dia: 60,
                  ex: -7500, ey: -15000, es: 800, ee: 0};
        vt[2] = '{a: 1, b: 2, c: 5, d: 0, dia: 1,
                  ex: -83, ey: 250, es: 8, ee: 0};
        vt[3] = '{a: 0, b: 0, c: 10, d: 0, dia: 60,
                  ex: 0, ey: 15000, es: 10, ee: 1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset X", longint'(x), 0);
        chk("reset Y", longint'(y), 0);
        chk("reset S", longint'(s), 0);
        chk("reset err", longint'(err), 0);
        chk("reset busy", busy, 0);
        chk("reset rdy", rdy, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++)
            run($sformatf("vec%0d", i), vt[i]);

        // random stimulus against the model
        for (int i = 0; i < 24; i++) begin
            logic [31:0] r[4];
            logic [15:0] rd;
            int mode;
            mode = $urandom_range(0, 3);
            for (int k = 0; k < 4; k++) r[k] = $urandom();
            rd = 16'($urandom());
            case (mode)
                1: for (int k = 0; k < 4; k++) r[k] = r[k] & 32'h3FF;
                2: begin
                    if ($urandom_range(0, 1) == 1) begin r[0] = 0; r[1] = 0; end
                    else begin r[2] = 0; r[3] = 0; end
                end
                3: begin
                    r[0] = 32'hFFFFFFFF; r[1] = 0;
                    r[2] = 0; r[3] = 32'hFFFFFFFF; rd = 16'hFFFF;
                end
                default: ;
            endcase
            run($sformatf("rand%0d", i), model(r[0], r[1], r[2], r[3], rd));
        end

        // held outputs stable while inputs wander
        v = model(32'd7, 32'd3, 32'd9, 32'd1, 16'd40);
        run("hold", v);
        a_in = 32'd1; b_in = 32'd900; dia = 16'd5;
        repeat (15) @(posedge clk);
        #1;
        chk_res("hold later", v);

        // data_valid pulse while busy is ignored
        begin
            longint d0;
`ifdef BPM_POS_DROP_CNT_EN
            d0 = longint'(drop_cnt);
`else
            d0 = 0;
`endif
            start(vt[0]);
            repeat (10) @(posedge clk);
            #1;
            data_valid = 1'b1;
            a_in = 32'd5;
            b_in = 32'd500;
            @(posedge clk); #1;
            data_valid = 1'b0;
            chk("ignore busy", busy, 1);
            wait_rdy();
            chk("ignore latency", cyc - t0, LAT);
            chk_res("ignore", vt[0]);
`ifdef BPM_POS_DROP_CNT_EN
            chk("drop_cnt", longint'(drop_cnt) - d0, 1);
`else
            chk("drop none", d0, 0);
`endif
        end

        // back-to-back with data_valid held through rdy
        @(negedge clk);
        drive(vt[0]);
        data_valid = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        wait_rdy();
        chk("b2b first latency", cyc - t0, LAT);
        chk_res("b2b first", vt[0]);
        drive(vt[2]);
        t0 = cyc;
        @(posedge clk); #1;
        chk("b2b accepted", busy, 1);
        wait_rdy();
        data_valid = 1'b0;
        chk("b2b gap", cyc - t0, LAT + 1);
        chk_res("b2b second", vt[2]);
        @(posedge clk); #1;
        chk("b2b idle after", busy, 0);

        // reset mid-operation, then request on first edge after release
        start(vt[1]);
        repeat (50) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst X", longint'(x), 0);
        chk("midrst Y", longint'(y), 0);
        chk("midrst S", longint'(s), 0);
        chk("midrst err", longint'(err), 0);
        chk("midrst busy", busy, 0);
        chk("midrst rdy", rdy, 0);
`ifdef BPM_POS_DROP_CNT_EN
        chk("midrst drop_cnt", longint'(drop_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        w = vt[3];
        drive(w);
        data_valid = 1'b1;
        @(posedge clk); #1;
        data_valid = 1'b0;
        t0 = cyc;
        chk("post-rst accept", busy, 1);
        wait_rdy();
        chk("post-rst latency", cyc - t0, LAT);
        chk_res("post-rst", w);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
